// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the clock set controller: mode/state values, counter widths
// and the mode-advance helper.
package clock_ctrl_pkg;

    localparam int IDLE_W   = 6;
    localparam int REPEAT_W = 16;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_SEC  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = MODE_RUN,
        ST_SET_HOUR = MODE_SET_HOUR,
        ST_SET_MIN  = MODE_SET_MIN,
        ST_SET_SEC  = MODE_SET_SEC
    } state_t;

    function automatic state_t next_mode(input state_t s);
        case (s)
            ST_RUN:      return ST_SET_HOUR;
            ST_SET_HOUR: return ST_SET_MIN;
            ST_SET_MIN:  return ST_SET_SEC;
            default:     return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_pulse.sv
// Button conditioner: 2-FF synchronizer, registered rising-edge pulse and optional
// hold-to-repeat pulses (down-counter, reload on terminal count).
module btn_pulse
    import clock_ctrl_pkg::*;
#(
    parameter bit                  REPEAT_EN  = 1'b0,
    parameter logic [REPEAT_W-1:0] REPEAT_DLY = 16'd50000,
    parameter logic [REPEAT_W-1:0] REPEAT_PER = 16'd20000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic                r_pulse;
    logic [REPEAT_W-1:0] r_rep_cnt;

    logic w_edge;
    logic w_held;
    logic w_rep_tc;

    assign w_edge   = r_sync2 & ~r_prev;
    assign w_held   = r_sync2 & r_prev;
    assign w_rep_tc = REPEAT_EN & w_held & (r_rep_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_prev    <= 1'b0;
            r_pulse   <= 1'b0;
            r_rep_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= w_edge | w_rep_tc;
            // Counter is loaded on the edge so the first repeat lands REPEAT_DLY
            // cycles after the edge pulse; with REPEAT_EN clear it folds to zero.
            if (!REPEAT_EN || !r_sync2) begin
                r_rep_cnt <= '0;
            end else if (w_edge) begin
                r_rep_cnt <= REPEAT_DLY - REPEAT_W'(1);
            end else if (w_rep_tc) begin
                r_rep_cnt <= REPEAT_PER - REPEAT_W'(1);
            end else begin
                r_rep_cnt <= r_rep_cnt - REPEAT_W'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode controller for the seconds/minutes/hours counter chain.
// Define CLOCK_SET_AUTOREPEAT_EN to build hold-to-repeat on the increment button.
//
// state       | meaning
// ST_RUN      | time runs from tick_1hz, carries cascade
// ST_SET_HOUR | time frozen, inc pulses hour_en
// ST_SET_MIN  | time frozen, inc pulses min_en
// ST_SET_SEC  | time frozen, inc pulses sec_clr
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter logic [REPEAT_W-1:0] REPEAT_DLY = 16'd50000,
    parameter logic [REPEAT_W-1:0] REPEAT_PER = 16'd20000,
    parameter logic [IDLE_W-1:0]   TIMEOUT_S  = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       sec_car,
    input  logic       min_car,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam bit INC_REPEAT = 1'b1;
`else
    localparam bit INC_REPEAT = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_inc;

    logic w_p_mode;
    logic w_p_inc;
    logic w_in_set;
    logic w_timeout;
    logic w_state_chg;
    logic w_inc_ok;

    logic w_sec_en;
    logic w_min_en;
    logic w_hour_en;
    logic w_sec_clr;
    logic r_sec_en;
    logic r_min_en;
    logic r_hour_en;
    logic r_sec_clr;
    logic r_blink;

    btn_pulse #(
        .REPEAT_EN  (1'b0),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_btn_mode (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_mode),
        .o_pulse (w_p_mode)
    );

    btn_pulse #(
        .REPEAT_EN  (INC_REPEAT),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_btn_inc (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_inc),
        .o_pulse (w_p_inc)
    );

    assign w_in_set   = (r_state != ST_RUN);
    assign w_idle_inc = r_idle + IDLE_W'(1);
    // The tick that brings the idle count to TIMEOUT_S is the exit edge itself.
    assign w_timeout  = w_in_set & tick_1hz & (w_idle_inc == TIMEOUT_S);

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = ST_RUN;
        end else if (w_p_mode) begin
            w_state_nxt = next_mode(r_state);
        end
    end

    assign w_state_chg = (w_state_nxt != r_state);
    assign w_inc_ok    = w_p_inc & ~w_state_chg;

    always_comb begin
        w_sec_en  = 1'b0;
        w_min_en  = 1'b0;
        w_hour_en = 1'b0;
        w_sec_clr = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_sec_en  = tick_1hz;
                w_min_en  = tick_1hz & sec_car;
                w_hour_en = tick_1hz & sec_car & min_car;
            end
            ST_SET_HOUR: w_hour_en = w_inc_ok;
            ST_SET_MIN:  w_min_en  = w_inc_ok;
            ST_SET_SEC:  w_sec_clr = w_inc_ok;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec_en  <= 1'b0;
            r_min_en  <= 1'b0;
            r_hour_en <= 1'b0;
            r_sec_clr <= 1'b0;
            r_blink   <= 1'b0;
            r_idle    <= '0;
        end else begin
            r_sec_en  <= w_sec_en;
            r_min_en  <= w_min_en;
            r_hour_en <= w_hour_en;
            r_sec_clr <= w_sec_clr;

            if (w_state_chg || !w_in_set) begin
                r_blink <= 1'b0;
            end else if (tick_1hz) begin
                r_blink <= ~r_blink;
            end

            if (w_p_mode || w_p_inc || w_state_chg) begin
                r_idle <= '0;
            end else if (w_in_set && tick_1hz) begin
                r_idle <= w_idle_inc;
            end
        end
    end

    assign sec_en  = r_sec_en;
    assign min_en  = r_min_en;
    assign hour_en = r_hour_en;
    assign sec_clr = r_sec_clr;
    assign mode    = r_state;
    assign blink   = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and randomized checks of clock_set_ctrl against an event-level reference model.
module tb_clock_set_ctrl;

    localparam int RDLY = 8;
    localparam int RPER = 4;
    localparam int TMO  = 5;
    localparam int QN   = 4096;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       sec_car;
    logic       min_car;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_en;
    logic       min_en;
    logic       hour_en;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    clock_set_ctrl #(
        .REPEAT_DLY (16'd8),
        .REPEAT_PER (16'd4),
        .TIMEOUT_S  (6'd5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .sec_car  (sec_car),
        .min_car  (min_car),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hour_en  (hour_en),
        .sec_clr  (sec_clr),
        .mode     (mode),
        .blink    (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: button events are scheduled by edge index (effect 3 edges after sampling).
    bit q_mode [QN];
    bit q_inc  [QN];
    int m_mode;
    int m_idle;
    bit m_blink;
    bit prev_bm;
    bit prev_bi;
    int hold_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    endtask

    function automatic logic [6:0] obs_vec();
        return {sec_en, min_en, hour_en, sec_clr, mode, blink};
    endfunction

    task automatic model_reset();
        foreach (q_mode[i]) begin
            q_mode[i] = 1'b0;
            q_inc[i]  = 1'b0;
        end
        m_mode     = 0;
        m_idle     = 0;
        m_blink    = 1'b0;
        prev_bm    = 1'b0;
        prev_bi    = 1'b0;
        hold_start = 0;
    endtask

    task automatic step(input bit t, input bit sc, input bit mc, input bit bm, input bit bi);
        bit pmv, piv, to;
        bit e_sec, e_min, e_hour, e_clr;
        int nm, d;
        tick_1hz = t;
        sec_car  = sc;
        min_car  = mc;
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        #1;
        cyc++;
        if (bm && !prev_bm) q_mode[(cyc + 3) % QN] = 1'b1;
        if (bi && !prev_bi) begin
            hold_start = cyc;
            q_inc[(cyc + 3) % QN] = 1'b1;
        end else if (bi && REP) begin
            d = cyc - hold_start;
            if (d >= RDLY && ((d - RDLY) % RPER) == 0) q_inc[(cyc + 3) % QN] = 1'b1;
        end
        prev_bm = bm;
        prev_bi = bi;
        pmv = q_mode[cyc % QN];
        piv = q_inc[cyc % QN];
        q_mode[cyc % QN] = 1'b0;
        q_inc[cyc % QN]  = 1'b0;

        to = (m_mode != 0) && t && (m_idle + 1 == TMO);
        e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0;
        if (m_mode == 0) begin
            e_sec  = t;
            e_min  = t & sc;
            e_hour = t & sc & mc;
        end else if (piv && !pmv && !to) begin
            case (m_mode)
                1: e_hour = 1'b1;
                2: e_min  = 1'b1;
                default: e_clr = 1'b1;
            endcase
        end
        nm = to ? 0 : (pmv ? (m_mode + 1) % 4 : m_mode);
        if (nm != m_mode) begin
            m_idle  = 0;
            m_blink = 1'b0;
        end else begin
            if (pmv || piv) m_idle = 0;
            else if (m_mode != 0 && t) m_idle++;
            if (m_mode == 0) m_blink = 1'b0;
            else if (t) m_blink = ~m_blink;
        end
        m_mode = nm;
        chk("outputs", obs_vec(), {e_sec, e_min, e_hour, e_clr, 2'(nm), m_blink});
    endtask

    task automatic run(input int n, input bit t, input bit sc, input bit mc, input bit bm, input bit bi);
        for (int i = 0; i < n; i++) step(t, sc, mc, bm, bi);
    endtask

    task automatic do_reset();
        tick_1hz = 0; sec_car = 0; min_car = 0; btn_mode = 0; btn_inc = 0;
        rst = 1'b0;
        #1;
        chk("reset_async", obs_vec(), 0);
        @(posedge clk);
        #1;
        cyc++;
        chk("reset_held", obs_vec(), 0);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int toggles, clr_seen, bm_hold, bi_hold;
        logic last_blink;
        logic [31:0] mask;
        bit rbm, rbi;

        rst = 1'b0;
        tick_1hz = 0; sec_car = 0; min_car = 0; btn_mode = 0; btn_inc = 0;
        model_reset();
        #3;
        chk("reset_init", obs_vec(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        step(1, 0, 0, 0, 0);
        chk("run_first_tick", {sec_en, min_en}, 2'b10);

        step(1, 1, 1, 0, 0);
        chk("cascade_all", {sec_en, min_en, hour_en}, 3'b111);
        step(0, 1, 1, 0, 0);
        chk("cascade_width", {sec_en, min_en, hour_en}, 3'b000);
        step(1, 1, 0, 0, 0);
        chk("cascade_no_hour", {sec_en, min_en, hour_en}, 3'b110);

        run(3, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("set_mode1", mode, 1);
        run(3, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("set_mode2", mode, 2);

        run(3, 0, 0, 0, 0, 1);
        chk("min_inc_early", min_en, 0);
        step(0, 0, 0, 0, 0);
        chk("min_inc_pulse", min_en, 1);
        step(0, 0, 0, 0, 0);
        chk("min_inc_width", min_en, 0);
        run(6, 0, 0, 0, 0, 0);

        run(3, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("set_mode3", mode, 3);
        run(3, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
        chk("sec_clr_pulse", {sec_clr, sec_en}, 2'b10);
        step(0, 0, 0, 0, 0);
        chk("sec_clr_width", sec_clr, 0);
        run(3, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("back_to_run", mode, 0);

        run(3, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("timeout_entry", mode, 1);
        toggles = 0;
        last_blink = blink;
        for (int k = 1; k <= TMO; k++) begin
            step(1, 1, 1, 0, 0);
            if (k < TMO) begin
                chk("freeze_mode", mode, 1);
                chk("blink_phase", blink, k % 2);
                chk("freeze_en", {sec_en, min_en, hour_en}, 0);
                if (blink !== last_blink) toggles++;
                last_blink = blink;
            end else begin
                chk("timeout_mode", mode, 0);
                chk("timeout_blink", blink, 0);
                chk("timeout_en", {sec_en, min_en, hour_en}, 0);
            end
            run(2, 0, 0, 0, 0, 0);
        end
        chk("blink_toggles", toggles, 4);

        run(3, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("simul_entry", mode, 1);
        run(3, 0, 0, 0, 1, 1); step(0, 0, 0, 0, 0);
        chk("simul_mode", mode, 2);
        chk("simul_no_hour", hour_en, 0);
        step(0, 0, 0, 0, 0);
        chk("simul_no_inc", {hour_en, min_en}, 0);
        run(4, 0, 0, 0, 0, 0);

        mask = 0;
        for (int i = 1; i <= 28; i++) begin
            step(0, 0, 0, 0, (i <= 20));
            if (min_en === 1'b1) mask |= (32'd1 << i);
        end
        chk("autorepeat_pulses", mask, REP ? 32'h0011_1010 : 32'h0000_0010);

        run(3, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
        chk("preset_mode3", mode, 3);
        run(2, 0, 0, 0, 0, 1);
        do_reset();
        clr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            if (sec_clr !== 1'b0) clr_seen++;
        end
        chk("reset_drops_pulse", clr_seen, 0);
        step(1, 0, 0, 0, 0);
        chk("post_reset_tick", sec_en, 1);

        bm_hold = 0;
        bi_hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            if (bm_hold > 0) begin
                rbm = 1'b1;
                bm_hold--;
            end else begin
                rbm = 1'b0;
                if ($urandom_range(0, 29) == 0) bm_hold = $urandom_range(1, 6);
            end
            if (bi_hold > 0) begin
                rbi = 1'b1;
                bi_hold--;
            end else begin
                rbi = 1'b0;
                if ($urandom_range(0, 9) == 0) bi_hold = $urandom_range(1, 22);
            end
            step(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), rbm, rbi);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
